// File: rtl/ram_test_pkg.sv
// Shared types, constants and pattern helpers for the PSRAM traffic generator/checker.
package ram_test_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned PAT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PAT_ADDR  = 2'd0,
    PAT_NADDR = 2'd1,
    PAT_LFSR  = 2'd2,
    PAT_CHK   = 2'd3
  } pattern_e;

  localparam logic [PAT_W-1:0] CHK_ODD  = 16'hAAAA;
  localparam logic [PAT_W-1:0] CHK_EVEN = 16'h5555;

  // Fibonacci step for x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    return {q[0] ^ q[2] ^ q[3] ^ q[5], q[LFSR_W-1:1]};
  endfunction

  // Data word expected at an address for the selected pattern.
  function automatic logic [PAT_W-1:0] pat_word(input pattern_e         p,
                                                input logic [PAT_W-1:0]  a,
                                                input logic [LFSR_W-1:0] lfsr);
    logic [PAT_W-1:0] w;
    case (p)
      PAT_ADDR:  w = a;
      PAT_NADDR: w = ~a;
      PAT_LFSR:  w = lfsr;
      default:   w = a[0] ? CHK_ODD : CHK_EVEN;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit pattern LFSR with synchronous reload and per-transaction advance.
module lfsr16
  import ram_test_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RST_VAL = 16'hACE1
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              adv,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      q_q <= RST_VAL;
    end else if (load) begin
      q_q <= seed;
    end else if (adv) begin
      q_q <= lfsr_step(q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ram_test_seq.sv
// PSRAM write-then-verify sequencer: one write pass and one compare pass over
// [START_ADDR, END_ADDR]; request lines only move on rdy so the controller sees stable values.
module ram_test_seq
  import ram_test_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 23,
  parameter int unsigned       DATA_W     = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = {ADDR_W{1'b1}},
  parameter logic [15:0]       LFSR_SEED  = 16'hACE1,
  parameter int unsigned       TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [1:0]        pattern,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              rdy,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);

  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned ERR_W = 16;

  state_e              state_q;
  pattern_e            pat_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic                timeout_q;
  logic [ERR_W-1:0]    err_q;
  logic [ADDR_W-1:0]   ferr_addr_q;
  logic [DATA_W-1:0]   ferr_data_q;
  logic [WD_W-1:0]     wd_q;

  logic [LFSR_W-1:0]   lfsr_q;
  logic [LFSR_W-1:0]   lfsr_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [ERR_W-1:0]    err_d;
  logic [DATA_W-1:0]   first_word;
  logic [DATA_W-1:0]   next_word;
  logic [DATA_W-1:0]   exp_word;
  logic                mismatch;
  logic                running;
  logic                start_ok;
  logic                at_end;
  logic                wd_expired;
  logic                lfsr_load;
  logic                lfsr_adv;

  lfsr16 #(
    .RST_VAL (LFSR_SEED)
  ) u_lfsr (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .load      (lfsr_load),
    .seed      (LFSR_SEED),
    .adv       (lfsr_adv),
    .q         (lfsr_q)
  );

  // Next-value helpers and LFSR control derived from the current state.
  always_comb begin
    running    = (state_q == ST_SYNC) || (state_q == ST_WRITE) || (state_q == ST_READ);
    start_ok   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    at_end     = (addr_q == END_ADDR);
    addr_d     = addr_q + ADDR_W'(1);
    lfsr_d     = lfsr_step(lfsr_q);
    err_d      = (err_q == {ERR_W{1'b1}}) ? err_q : err_q + ERR_W'(1);
    first_word = DATA_W'(pat_word(pat_q, PAT_W'(START_ADDR), lfsr_q));
    next_word  = DATA_W'(pat_word(pat_q, PAT_W'(addr_d), lfsr_d));
    exp_word   = DATA_W'(pat_word(pat_q, PAT_W'(addr_q), lfsr_q));
    mismatch   = (mem_rdata != exp_word);
    wd_expired = running && !rdy && (wd_q == WD_W'(TIMEOUT - 1));
    lfsr_load  = 1'b0;
    lfsr_adv   = 1'b0;
    if (start_ok) begin
      lfsr_load = 1'b1;
    end else if (rdy && !wd_expired) begin
      if (state_q == ST_WRITE) begin
        lfsr_load = at_end;
        lfsr_adv  = !at_end;
      end else if (state_q == ST_READ) begin
        lfsr_adv  = !at_end;
      end
    end
  end

  // Sequencer state, request lines, watchdog and result registers.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      pat_q       <= PAT_ADDR;
      we_q        <= 1'b0;
      addr_q      <= START_ADDR;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
      wd_q        <= '0;
    end else begin
      if (rdy || start_ok) begin
        wd_q <= '0;
      end else if (running) begin
        wd_q <= wd_q + WD_W'(1);
      end

      if (start_ok) begin
        state_q     <= ST_SYNC;
        pat_q       <= pattern_e'(pattern);
        busy_q      <= 1'b1;
        done_q      <= 1'b0;
        pass_q      <= 1'b0;
        timeout_q   <= 1'b0;
        err_q       <= '0;
        ferr_addr_q <= '0;
        ferr_data_q <= '0;
      end else if (wd_expired) begin
        state_q   <= ST_DONE;
        timeout_q <= 1'b1;
        we_q      <= 1'b0;
        busy_q    <= 1'b0;
        done_q    <= 1'b1;
        pass_q    <= 1'b0;
      end else if (running && rdy) begin
        case (state_q)
          ST_SYNC: begin
            we_q    <= 1'b1;
            addr_q  <= START_ADDR;
            wdata_q <= first_word;
            state_q <= ST_WRITE;
          end
          ST_WRITE: begin
            if (at_end) begin
              we_q    <= 1'b0;
              addr_q  <= START_ADDR;
              state_q <= ST_READ;
            end else begin
              addr_q  <= addr_d;
              wdata_q <= next_word;
            end
          end
          ST_READ: begin
            if (mismatch) begin
              err_q <= err_d;
              if (err_q == '0) begin
                ferr_addr_q <= addr_q;
                ferr_data_q <= mem_rdata;
              end
            end
            if (at_end) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_q == '0) && !mismatch;
            end else begin
              addr_q <= addr_d;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_we         = we_q;
  assign mem_addr       = 32'(addr_q);
  assign mem_wdata      = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_cnt        = err_q;
  assign first_err_addr = ferr_addr_q;
  assign first_err_data = ferr_data_q;

endmodule

// File: doc/ram_test_seq.md
Name: ram_test_seq

Overview:
- Upstream traffic generator and checker for the asynchronous PSRAM controller on the Nexys3 board. It drives the controller's sample-and-hold request interface (mem_we, mem_addr, mem_wdata) and consumes rdy and mem_rdata.
- On start it runs one write pass over an address range, then one read/compare pass, using a selectable data pattern.
- It reports pass/fail, an error count and first-failure details to the top level (LEDs/7-seg).

Parameters:
- ADDR_W, 23, used address width; mem_addr[31:ADDR_W] tied to 0.
- DATA_W, 16, data word width.
- START_ADDR, 0, first address tested.
- END_ADDR, 23'h7FFFFF, last address tested (inclusive); must be >= START_ADDR.
- LFSR_SEED, 16'hACE1, LFSR seed; must be non-zero.
- TIMEOUT, 1023, max clk cycles waited for rdy before abort.

Ports:
- clk  in  1  system clock (<=80 MHz)
- sys_rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a test when idle
- pattern  in  2  0=addr[15:0], 1=~addr[15:0], 2=LFSR, 3=checkerboard (addr[0]?16'hAAAA:16'h5555); sampled at start
- mem_we  out  1  to controller: 1=write, 0=read
- mem_addr  out  32  to controller address
- mem_wdata  out  16  to controller write data
- mem_rdata  in  16  from controller, valid in rdy cycle
- rdy  in  1  from controller, one-cycle completion pulse
- busy  out  1  test in progress
- done  out  1  level; test finished, held until next start
- pass  out  1  done && err_cnt==0 && !timeout
- timeout  out  1  level; rdy not seen within TIMEOUT cycles
- err_cnt  out  16  read mismatches, saturating at 16'hFFFF
- first_err_addr  out  23  address of first mismatch
- first_err_data  out  16  data read at first mismatch

Behaviour:
- Reset: busy=0, done=0, timeout=0, err_cnt=0, first_err_addr=0, first_err_data=0, mem_we=0, mem_addr=START_ADDR, mem_wdata=0, LFSR=LFSR_SEED, state=IDLE.
- Handshake rule: the controller runs transactions back to back and samples the request lines mid-transaction. mem_we, mem_addr and mem_wdata are registered and change ONLY in a cycle where rdy=1, so new values are stable from the controller's next P0 onward. rdy is ignored in IDLE and DONE.
- States and transitions:
  - IDLE: mem_we=0. start moves to SYNC; it latches pattern, clears done/timeout/err_cnt/first_err_*, sets busy=1, LFSR=LFSR_SEED.
  - SYNC: absorbs the in-flight transaction. On rdy: mem_we=1, mem_addr=START_ADDR, mem_wdata=pat(START_ADDR); go to WRITE.
  - WRITE: on rdy (write at mem_addr done), if mem_addr==END_ADDR: mem_we=0, mem_addr=START_ADDR, LFSR reseeded; go to READ. Otherwise mem_addr+1, mem_wdata=pat(next), LFSR advances.
  - READ: on rdy, compare mem_rdata against pat(mem_addr). On mismatch, err_cnt+1 (saturating); if this is the first error, capture first_err_addr/data. If mem_addr==END_ADDR, go to DONE; else mem_addr+1, LFSR advances.
  - DONE: busy=0, done=1, mem_we=0. start behaves as in IDLE.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, advances once per completed transaction. The read pass regenerates the write-pass sequence exactly.
- Watchdog: a counter clears on every rdy and on start. If it reaches TIMEOUT in SYNC/WRITE/READ: timeout=1, go to DONE (pass=0).
- start while busy: ignored.
- START_ADDR==END_ADDR: exactly one write and one read.
- Reset mid-test: returns immediately to reset values; no partial results are retained.
- Address arithmetic is ADDR_W-bit; END_ADDR=all-ones terminates on compare and never wraps.

Decomposition:
- Shared package ram_test_pkg holds:
  - state encodings (IDLE, SYNC, WRITE, READ, DONE)
  - pattern codes (PAT_ADDR, PAT_NADDR, PAT_LFSR, PAT_CHK)
  - checkerboard constants 16'hAAAA/16'h5555
- One sub-module, lfsr16: inputs clk, sys_rst_n, load, seed, adv; output q.

Test Plan:
- Behavioural PSRAM + controller model (rdy every 8 cycles), START=0, END=7, pattern=0, start pulse: writes 0..7 with data 0..7, then 8 reads; done=1, pass=1, err_cnt=0, busy low after the 16th transaction completes.
- Same setup, pattern=2: write data sequence begins 16'hACE1, then the LFSR successor; the read pass matches; pass=1.
- pattern=3, model forces address 5 to read 16'h0000: err_cnt=1, first_err_addr=5, first_err_data=16'h0000, pass=0.
- Model stuck-at-bit0 on all reads, pattern=0, END=7: err_cnt=4, first_err_addr=0 (data 0 reads back 0x0001), pass=0.
- Model stops issuing rdy after 3 writes, TIMEOUT=1023: timeout=1 exactly 1023 cycles after the last rdy, done=1, pass=0; a new start clears timeout.
- Check that mem_addr/mem_we/mem_wdata change only in rdy cycles. Assert start during WRITE: ignored. Assert reset in READ: all outputs return to reset values next cycle.
